uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares a single 8N1 UART transmit line between NUM_REQ byte producers, such as status reporters, a debug echo and a heartbeat. It arbitrates round-robin among requesters using a valid/ready handshake per requester. It serializes the granted byte at a baud rate derived from the 12 MHz internal oscillator. It sits between on-chip byte sources and the uarttx pad in the iCE40 top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
BAUD_DIV, 1250, clk cycles per UART bit (12 MHz / 9600).
IDW, $clog2(NUM_REQ), width of grant_id (derived; not overridden).

Ports:
clk  input  1  system clock (12 MHz from SB_HFOSC).
rst  input  1  reset; asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester byte available.
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
req_ready  output  NUM_REQ  per-requester accept strobe.
tx  output  1  UART serial output, idle high.
busy  output  1  frame in progress.
grant_id  output  IDW  index of the most recently granted requester.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, tx=1, busy=0, req_ready=0, grant_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Bit counter=0, baud counter=0.
- Reset asserted mid-frame:
  - tx returns to 1 immediately.
  - The frame is abandoned; no retransmit.
  - Any accepted byte is lost.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally while in IDLE and any req_valid is set; all other req_ready bits are 0.
  - Transfer occurs on the clk edge where req_valid[i] and req_ready[i] are both 1.
  - On that edge: latch the byte, grant_id<=winner, last<=winner, baud counter<=0, state<=START.
  - No req_valid set: stay in IDLE, tx=1.
- START: tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0], LSB first; each bit is held BAUD_DIV cycles.
  - After bit 7 completes, go to STOP.
- STOP: tx=1 for BAUD_DIV cycles, then go to IDLE.
- Timing:
  - tx first goes low on the cycle after the transfer edge.
  - Frame length is exactly 10*BAUD_DIV cycles.
  - Minimum gap between frames is 1 clk cycle (the IDLE arbitration cycle), giving 10*BAUD_DIV+1 cycles per back-to-back frame.
- busy=1 in START, DATA and STOP; 0 in IDLE.
- tx is registered: no glitches, and no combinational path from req_* to tx.
- Requester rules:
  - Must hold req_data stable while req_valid=1 and req_ready=0.
  - May deassert req_valid before it is granted; no transfer happens and no state changes.
- req_valid rising during a frame: ignored until IDLE, then arbitrated normally.
- All NUM_REQ valid continuously: grants rotate 0,1,2,...,NUM_REQ-1,0,... with no starvation.
- Single requester valid continuously: it is granted every frame.
- Baud counter: width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1, wraps, and advances the bit on the wrap.

Optional Feature:
UART_ARB_FIXED_PRIO_EN
- Defined:
  - Winner is the lowest index with req_valid set; the round-robin pointer is not used.
  - Requester 0 can starve the others.
  - grant_id still reports the winner.
- Undefined: round-robin arbitration as specified above (default).

Test Plan:
- Reset, BAUD_DIV=4, req_valid=0001, req_data[7:0]=8'h44 ("D"):
  - req_ready=0001 in IDLE.
  - tx sequence per 4 cycles: 0,0,0,1,0,0,0,1,0,1.
  - busy high for 40 cycles.
  - grant_id=0.
- BAUD_DIV=4, req_valid=1111 held, data i=8'h30+i:
  - Frames carry 8'h30, 31, 32, 33, 30 in order.
  - Each frame starts 41 cycles after the previous one.
- BAUD_DIV=4, requester 2 raises valid 5 cycles into a frame from requester 1:
  - req_ready[2]=0 until IDLE.
  - Granted next; grant_id=2.
- BAUD_DIV=4, rst pulsed during DATA bit 3:
  - tx=1 and busy=0 within the same cycle.
  - grant_id=0.
  - With requester 3 valid after release, it is granted and a full clean frame follows.
- Requester 1 asserts valid, then deasserts it during a frame owned by requester 0 → no req_ready[1] pulse and no frame from requester 1.
- UART_ARB_FIXED_PRIO_EN defined, req_valid=1011 held → grants are 0,0,0,... and requesters 1 and 3 are never granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int BAUD_DIV = 1250,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int unsigned   NR        = NUM_REQ;
    localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] last, last_n;
    logic [IDW-1:0] grant_n;
    logic [BW-1:0]  baud, baud_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shift, shift_n;
    logic           tx_n;
    logic           any_valid;
    logic [IDW-1:0] winner;
    logic [7:0]     win_byte;
    logic           baud_wrap;

    // Winner selection
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NR; i++) begin
            if (!any_valid && req_valid[i]) begin
                any_valid = 1'b1;
                winner    = IDW'(i);
            end
        end
`else
        // Search starts just after the last grant so every requester gets a turn.
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = (32'(last) + k) % NR;
            if (!any_valid && req_valid[IDW'(idx)]) begin
                any_valid = 1'b1;
                winner    = IDW'(idx);
            end
        end
`endif
    end

    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (winner == IDW'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    assign baud_wrap = (baud == BAUD_LAST);
    assign busy      = (state != IDLE);

    // Next-state logic; tx is computed one cycle ahead so it can be registered.
    always_comb begin
        state_n   = state;
        last_n    = last;
        grant_n   = grant_id;
        baud_n    = baud;
        bit_n     = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        req_ready = '0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                for (int unsigned i = 0; i < NR; i++) begin
                    req_ready[i] = any_valid && (winner == IDW'(i));
                end
                if (any_valid) begin
                    shift_n = win_byte;
                    grant_n = winner;
                    last_n  = winner;
                    baud_n  = '0;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                baud_n = baud + 1'b1;
                if (baud_wrap) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                baud_n = baud + 1'b1;
                if (baud_wrap) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                baud_n = baud + 1'b1;
                tx_n   = 1'b1;
                if (baud_wrap) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            grant_id <= '0;
            last     <= IDW'(NUM_REQ - 1);
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            grant_id <= grant_n;
            last     <= last_n;
            baud     <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a tx-line monitor decodes frames and checks them
// against a queue of expected (byte, grant) entries pushed by the stimulus.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [31:0]   req_data;
    logic [NR-1:0] req_ready;
    logic          tx;
    logic          busy;
    logic [1:0]    grant_id;

    uart_tx_arbiter #(.NUM_REQ(NR), .BAUD_DIV(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned id;
        int unsigned gap;
    } exp_t;
    exp_t exp_q[$];

    bit          mon_active = 1'b0;
    int unsigned mon_cnt    = 0;
    int unsigned mon_busy   = 0;
    int unsigned mon_frames = 0;
    int unsigned cur_start  = 0;
    int unsigned prev_start = 0;
    logic [7:0]  mon_byte   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] d, input int unsigned id, input int unsigned gap);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int unsigned i, input logic [7:0] d);
        req_data = (req_data & ~(32'hFF << (8 * i))) | (32'(d) << (8 * i));
    endtask

    // Raise valid for requester i, wait for its grant, then drop valid after the transfer edge.
    task automatic send(input int unsigned i, input logic [7:0] d);
        bit got;
        got = 1'b0;
        set_byte(i, d);
        req_valid = req_valid | (NR'(1) << i);
        for (int n = 0; n < 200; n++) begin
            #1;
            if (((32'(req_ready) >> i) & 32'd1) == 32'd1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("grant_wait", 32'(got), 32'd1);
        if (got) step();
        req_valid = req_valid & ~(NR'(1) << i);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0 && !mon_active) break;
            step();
        end
        check("drain", 32'(exp_q.size() == 0 && !mon_active), 32'd1);
    endtask

    task automatic wait_frames(input int unsigned target);
        for (int n = 0; n < 500; n++) begin
            if (mon_frames >= target) break;
            step();
        end
        check("frames_seen", 32'(mon_frames >= target), 32'd1);
    endtask

    // tx-line monitor: frame cycle 0 is the first negedge with tx low; bits sampled mid-bit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_busy   = 0;
                    mon_byte   = '0;
                    cur_start  = cyc;
                    mon_frames++;
                end
                if (mon_active) begin
                    if (busy === 1'b1) mon_busy++;
                    if (mon_cnt % BAUD == BAUD / 2) begin
                        if (mon_cnt / BAUD == 0)
                            check("start_bit", 32'(tx), 32'd0);
                        else if (mon_cnt / BAUD <= 8)
                            mon_byte = {tx, mon_byte[7:1]};
                        else
                            check("stop_bit", 32'(tx), 32'd1);
                    end
                    if (mon_cnt == FRAME - 1) begin
                        if (exp_q.size() == 0) begin
                            check("frame_unexpected", 32'(mon_byte), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_data", 32'(mon_byte), 32'(e.data));
                            check("frame_grant", 32'(grant_id), e.id);
                            check("frame_busy_cycles", mon_busy, 32'(FRAME));
                            if (e.gap != 0) check("frame_gap", cur_start - prev_start, e.gap);
                        end
                        prev_start = cur_start;
                    end
                    if (mon_cnt == FRAME) begin
                        check("idle_busy", 32'(busy), 32'd0);
                        check("idle_tx", 32'(tx), 32'd1);
                        mon_active = 1'b0;
                    end
                    mon_cnt++;
                end
            end
        end
    end

    initial begin
        int unsigned base;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        step();
        step();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;
        step();

        // Single requester 0 sending 'D'
        set_byte(0, 8'h44);
        req_valid = 4'b0001;
        #1;
        check("ready_single", 32'(req_ready), 32'h1);
        push(8'h44, 0, 0);
        send(0, 8'h44);
        drain();

`ifndef UART_ARB_FIXED_PRIO_EN
        // All valid: grants rotate from 0 after reset, frames 41 cycles apart
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int unsigned i = 0; i < 4; i++) set_byte(i, 8'h30 + 8'(i));
        push(8'h30, 0, 0);
        push(8'h31, 1, 41);
        push(8'h32, 2, 41);
        push(8'h33, 3, 41);
        push(8'h30, 0, 41);
        base = mon_frames;
        req_valid = 4'b1111;
        wait_frames(base + 5);
        req_valid = '0;
        drain();

        // Requester 2 arrives mid-frame of requester 1; held off until IDLE, then granted
        push(8'h51, 1, 0);
        send(1, 8'h51);
        repeat (5) step();
        set_byte(2, 8'h62);
        req_valid = 4'b0100;
        push(8'h62, 2, 41);
        for (int n = 0; n < 200; n++) begin
            #1;
            if (req_ready[2] === 1'b1) break;
            if (busy === 1'b1) check("ready2_held", 32'(req_ready[2]), 32'd0);
            step();
        end
        check("ready2_granted", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        drain();
`else
        // Fixed priority: requester 0 wins every frame over 1 and 3
        set_byte(0, 8'hC0);
        set_byte(1, 8'hC1);
        set_byte(3, 8'hC3);
        push(8'hC0, 0, 0);
        push(8'hC0, 0, 41);
        push(8'hC0, 0, 41);
        base = mon_frames;
        req_valid = 4'b1011;
        wait_frames(base + 3);
        req_valid = '0;
        drain();
`endif

        // Reset during DATA bit 3 of a frame from requester 2 (0xA5, bit 3 = 0)
        send(2, 8'hA5);
        repeat (17) step();
        check("pre_rst_tx", 32'(tx), 32'd0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        push(8'h3C, 3, 0);
        send(3, 8'h3C);
        drain();

        // Requester 1 withdraws during requester 0's frame: never readied, never sent
        push(8'h0F, 0, 0);
        send(0, 8'h0F);
        repeat (3) step();
        set_byte(1, 8'h77);
        req_valid = 4'b0010;
        for (int n = 0; n < 10; n++) begin
            step();
            check("ready1_withdrawn", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        drain();
        repeat (5) step();
        check("ready_after_withdraw", 32'(req_ready), 32'd0);
        check("grant_after_withdraw", 32'(grant_id), 32'd0);
        check("no_extra_frames", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
